// File: rtl/brick_pkg.sv
// Shared widths and FSM state type for the brick hit arbiter.
package brick_pkg;
  localparam int unsigned NUM_BRICKS = 15;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned SCORE_W    = 8;
  localparam int unsigned SCORE_MAX  = (1 << SCORE_W) - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    LOCKOUT = 2'd2,
    CLEAR   = 2'd3
  } state_t;
endpackage

// File: rtl/brick_hit_arbiter_if.sv
// Game-side bundle between the collision logic and the brick arbiter.
interface brick_hit_arbiter_if;
  import brick_pkg::*;

  logic                  frame_tick;
  logic                  start;
  logic [NUM_BRICKS-1:0] collide;
  logic [NUM_BRICKS-1:0] alive;
  logic                  hit_valid;
  logic [IDX_W-1:0]      hit_idx;
  logic [SCORE_W-1:0]    score;
  logic [IDX_W-1:0]      bricks_left;
  logic                  level_clear;

  modport master (
    output frame_tick, start, collide,
    input  alive, hit_valid, hit_idx, score, bricks_left, level_clear
  );

  modport slave (
    input  frame_tick, start, collide,
    output alive, hit_valid, hit_idx, score, bricks_left, level_clear
  );
endinterface

// File: rtl/brick_prio_enc.sv
// Lowest-index-wins priority encoder over the brick request vector.
module brick_prio_enc
  import brick_pkg::*;
(
  input  logic [NUM_BRICKS-1:0] req,
  output logic                  any,
  output logic [IDX_W-1:0]      idx
);

  assign any = |req;

  // Scan from the top so the lowest set bit is written last.
  always_comb begin
    idx = '0;
    for (int i = NUM_BRICKS - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/brick_hit_arbiter.sv
// Picks one brick per collision, tracks alive mask/score, and enforces a frame-based lockout.
module brick_hit_arbiter
  import brick_pkg::*;
#(
  parameter int unsigned LOCKOUT_FRAMES = 2,
  parameter int unsigned SCORE_STEP     = 1
) (
  input logic          clk,
  input logic          rst,
  brick_hit_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (LOCKOUT_FRAMES < 1) ? 1 : $clog2(LOCKOUT_FRAMES + 1);

  state_t                state, state_n;
  logic [NUM_BRICKS-1:0] alive, alive_n;
  logic [IDX_W-1:0]      left, left_n;
  logic [SCORE_W-1:0]    score, score_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic                  hit_valid, hit_valid_n;
  logic [IDX_W-1:0]      hit_idx, hit_idx_n;
  logic                  level_clear;
  logic                  lock_exit;

  logic                  win_any;
  logic [IDX_W-1:0]      win_idx;
  logic [31:0]           score_sum;
  logic [SCORE_W-1:0]    score_sat;

  brick_prio_enc u_prio (
    .req (bus.collide & alive),
    .any (win_any),
    .idx (win_idx)
  );

  assign score_sum = 32'(score) + SCORE_STEP;
  assign score_sat = (score_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(score_sum);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      alive       <= '1;
      left        <= IDX_W'(NUM_BRICKS);
      score       <= '0;
      cnt         <= '0;
      hit_valid   <= 1'b0;
      hit_idx     <= '0;
      level_clear <= 1'b0;
    end else begin
      state       <= state_n;
      alive       <= alive_n;
      left        <= left_n;
      score       <= score_n;
      cnt         <= cnt_n;
      hit_valid   <= hit_valid_n;
      hit_idx     <= hit_idx_n;
      level_clear <= (state_n == CLEAR);
    end
  end

  always_comb begin
    state_n     = state;
    alive_n     = alive;
    left_n      = left;
    score_n     = score;
    cnt_n       = cnt;
    hit_valid_n = 1'b0;
    hit_idx_n   = hit_idx;
    lock_exit   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) state_n = PLAY;
      end

      PLAY: begin
        if (win_any) begin
          alive_n     = alive & ~(NUM_BRICKS'(1) << win_idx);
          if (left != '0) left_n = left - IDX_W'(1);
          score_n     = score_sat;
          cnt_n       = CNT_W'(LOCKOUT_FRAMES);
          hit_valid_n = 1'b1;
          hit_idx_n   = win_idx;
          state_n     = LOCKOUT;
        end
      end

      // A zero count (LOCKOUT_FRAMES=0) leaves without waiting for a frame tick.
      LOCKOUT: begin
        if (cnt == '0) begin
          lock_exit = 1'b1;
        end else if (bus.frame_tick) begin
          cnt_n     = cnt - CNT_W'(1);
          lock_exit = (cnt == CNT_W'(1));
        end
        if (lock_exit) state_n = (left == '0) ? CLEAR : PLAY;
      end

      CLEAR: begin
        if (bus.start) begin
          alive_n = '1;
          left_n  = IDX_W'(NUM_BRICKS);
          state_n = PLAY;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.alive       = alive;
  assign bus.hit_valid   = hit_valid;
  assign bus.hit_idx     = hit_idx;
  assign bus.score       = score;
  assign bus.bricks_left = left;
  assign bus.level_clear = level_clear;

endmodule

// File: tb/tb_brick_hit_arbiter.sv
// Directed bench for brick_hit_arbiter: default instance plus a no-lockout, large-step instance.
module tb_brick_hit_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  brick_hit_arbiter_if a_if ();
  brick_hit_arbiter_if b_if ();

  brick_hit_arbiter #(.LOCKOUT_FRAMES(2), .SCORE_STEP(1)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  brick_hit_arbiter #(.LOCKOUT_FRAMES(0), .SCORE_STEP(127)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [14:0] exp_alive;
  logic [7:0]  exp_score;
  logic [3:0]  exp_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the full observable state of instance A.
  task automatic chk_a(input string tag, input logic hv, input logic [3:0] idx, input logic lc);
    chk({tag, ".hit_valid"}, 32'(a_if.hit_valid), 32'(hv));
    if (hv) chk({tag, ".hit_idx"}, 32'(a_if.hit_idx), 32'(idx));
    chk({tag, ".alive"}, 32'(a_if.alive), 32'(exp_alive));
    chk({tag, ".score"}, 32'(a_if.score), 32'(exp_score));
    chk({tag, ".bricks_left"}, 32'(a_if.bricks_left), 32'(exp_left));
    chk({tag, ".level_clear"}, 32'(a_if.level_clear), 32'(lc));
  endtask

  task automatic ft_pulse();
    a_if.frame_tick = 1'b1;
    tick();
    a_if.frame_tick = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    a_if.frame_tick = 1'b0; a_if.start = 1'b0; a_if.collide = '0;
    b_if.frame_tick = 1'b0; b_if.start = 1'b0; b_if.collide = '0;
    exp_alive = 15'h7FFF; exp_score = 8'd0; exp_left = 4'd15;

    #12;
    chk_a("reset", 1'b0, 4'd0, 1'b0);
    chk("reset.hit_idx", 32'(a_if.hit_idx), 32'd0);
    chk("b_reset.alive", 32'(b_if.alive), 32'h7FFF);
    chk("b_reset.score", 32'(b_if.score), 32'd0);
    rst = 1'b1;

    // IDLE ignores collisions
    a_if.collide = 15'h0008;
    tick();
    chk_a("idle_ignore", 1'b0, 4'd0, 1'b0);

    // Start then single hit on brick 3
    a_if.collide = '0; a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0; a_if.collide = 15'h0008;
    tick();
    exp_alive = 15'h7FF7; exp_score = 8'd1; exp_left = 4'd14;
    chk_a("hit3", 1'b1, 4'd3, 1'b0);
    a_if.collide = '0;
    tick();
    chk_a("hit3_pulse_end", 1'b0, 4'd0, 1'b0);
    a_if.frame_tick = 1'b1; tick(); a_if.frame_tick = 1'b0; tick();
    a_if.frame_tick = 1'b1; tick(); a_if.frame_tick = 1'b0;

    // Simultaneous 2 and 4: only 2 wins, 4 ignored through lockout
    a_if.collide = 15'h0014;
    tick();
    exp_alive = 15'h7FF3; exp_score = 8'd2; exp_left = 4'd13;
    chk_a("multi", 1'b1, 4'd2, 1'b0);
    a_if.collide = 15'h0010;
    a_if.frame_tick = 1'b1; tick();
    chk_a("lock4_a", 1'b0, 4'd0, 1'b0);
    a_if.frame_tick = 1'b0; tick();
    a_if.frame_tick = 1'b1; tick();
    chk_a("lock4_b", 1'b0, 4'd0, 1'b0);
    a_if.frame_tick = 1'b0; a_if.collide = '0;
    tick();

    // Held collide on brick 0 with a coincident frame tick
    a_if.collide = 15'h0001; a_if.frame_tick = 1'b1;
    tick();
    exp_alive = 15'h7FF2; exp_score = 8'd3; exp_left = 4'd12;
    chk_a("hit0", 1'b1, 4'd0, 1'b0);
    a_if.frame_tick = 1'b0; tick();
    chk_a("hit0_hold", 1'b0, 4'd0, 1'b0);
    a_if.frame_tick = 1'b1; tick();
    a_if.frame_tick = 1'b0; a_if.collide = 15'h0003;
    tick();
    chk_a("coincident_tick_not_counted", 1'b0, 4'd0, 1'b0);
    a_if.collide = 15'h0001; a_if.frame_tick = 1'b1;
    tick();
    a_if.frame_tick = 1'b0;
    tick();
    chk_a("dead0_after_lockout", 1'b0, 4'd0, 1'b0);
    a_if.collide = '0;

    // Clear the rest of the level
    for (int i = 1; i < 15; i++) begin
      if (i != 2 && i != 3) begin
        a_if.collide = 15'(1) << i;
        tick();
        exp_alive[i] = 1'b0;
        exp_score = exp_score + 8'd1;
        exp_left = exp_left - 4'd1;
        chk_a($sformatf("sweep%0d", i), 1'b1, 4'(i), 1'b0);
        a_if.collide = '0;
        ft_pulse();
        ft_pulse();
      end
    end
    chk_a("cleared", 1'b0, 4'd0, 1'b1);
    chk("cleared.left_zero", 32'(a_if.bricks_left), 32'd0);

    // Restart from CLEAR keeps score
    a_if.start = 1'b1;
    tick();
    a_if.start = 1'b0;
    exp_alive = 15'h7FFF; exp_left = 4'd15;
    chk_a("restart", 1'b0, 4'd0, 1'b0);
    chk("restart.score15", 32'(a_if.score), 32'd15);

    // Reset in the middle of a hit pulse
    a_if.collide = 15'h0020;
    tick();
    exp_alive = 15'h7FDF; exp_score = 8'd16; exp_left = 4'd14;
    chk_a("pre_reset_hit", 1'b1, 4'd5, 1'b0);
    a_if.collide = '0;
    rst = 1'b0;
    #1;
    exp_alive = 15'h7FFF; exp_score = 8'd0; exp_left = 4'd15;
    chk_a("async_reset", 1'b0, 4'd0, 1'b0);
    chk("async_reset.hit_idx", 32'(a_if.hit_idx), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    a_if.collide = 15'h0020;
    tick();
    chk_a("post_reset_idle", 1'b0, 4'd0, 1'b0);
    tick();
    chk_a("post_reset_idle2", 1'b0, 4'd0, 1'b0);
    a_if.collide = '0;

    // Instance B: no lockout frames, saturating score
    b_if.start = 1'b1;
    tick();
    b_if.start = 1'b0; b_if.collide = 15'h0001;
    tick();
    chk("b_hit0.hv", 32'(b_if.hit_valid), 32'd1);
    chk("b_hit0.score", 32'(b_if.score), 32'd127);
    b_if.collide = 15'h0002;
    tick();
    chk("b_lock.hv", 32'(b_if.hit_valid), 32'd0);
    chk("b_lock.alive", 32'(b_if.alive), 32'h7FFE);
    tick();
    chk("b_hit1.hv", 32'(b_if.hit_valid), 32'd1);
    chk("b_hit1.idx", 32'(b_if.hit_idx), 32'd1);
    chk("b_hit1.score", 32'(b_if.score), 32'd254);
    b_if.collide = 15'h0004;
    tick();
    tick();
    chk("b_hit2.score_sat", 32'(b_if.score), 32'd255);
    b_if.collide = 15'h0008;
    tick();
    tick();
    chk("b_hit3.score_hold", 32'(b_if.score), 32'd255);
    chk("b_hit3.left", 32'(b_if.bricks_left), 32'd11);
    chk("b_hit3.alive", 32'(b_if.alive), 32'h7FF0);
    b_if.collide = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/brick_hit_arbiter.md
BRICK_HIT_ARBITER -- requirements
Module: brick_hit_arbiter

Interface
REQ-001 Parameter LOCKOUT_FRAMES, default 2: number of frame_tick pulses during which collisions are ignored after a hit.
REQ-002 Parameter SCORE_STEP, default 1: points added per destroyed brick.
REQ-003 Port clk  input  1: single system clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-low.
REQ-005 Port frame_tick  input  1: one-cycle pulse per video frame.
REQ-006 Port start  input  1: level-start request, sampled each cycle.
REQ-007 Port collide  input  15: per-brick collision flags, bit i = brick i, level-sensitive.
REQ-008 Port alive  output  15: per-brick alive mask, bit i = brick i.
REQ-009 Port hit_valid  output  1: one-cycle pulse when a brick is destroyed.
REQ-010 Port hit_idx  output  4: index of the destroyed brick; valid only while hit_valid=1.
REQ-011 Port score  output  8: accumulated score, saturating.
REQ-012 Port bricks_left  output  4: count of set alive bits.
REQ-013 Port level_clear  output  1: high while in state CLEAR.

Function
REQ-014 FSM states: IDLE, PLAY, LOCKOUT, CLEAR.
REQ-015 IDLE: collide ignored; start=1 -> PLAY next edge.
REQ-016 PLAY: effective hits = collide AND alive; if nonzero, the lowest set index wins.
REQ-017 Hit at edge N in PLAY: the winning alive bit clears at edge N, score and bricks_left update at edge N, state -> LOCKOUT, lockout counter loads LOCKOUT_FRAMES.
REQ-018 hit_valid/hit_idx are high for exactly the cycle after edge N (one-clock latency from sampled collide).
REQ-019 At most one brick is destroyed per hit; other simultaneous flags are dropped, not queued.
REQ-020 Collide on a dead brick has no effect in any state.
REQ-021 LOCKOUT: all collide ignored; each frame_tick decrements the counter.
REQ-022 LOCKOUT exit, counter reaching 0: bricks_left=0 -> CLEAR, else -> PLAY.
REQ-023 LOCKOUT_FRAMES=0: LOCKOUT exits on the next edge without waiting for frame_tick.
REQ-024 frame_tick coincident with a hit in PLAY: the hit is processed; that tick is not counted.
REQ-025 score = min(score + SCORE_STEP, 255); it never wraps.
REQ-026 bricks_left decrements by exactly 1 per hit and never underflows.
REQ-027 CLEAR: level_clear=1; start=1 -> alive=all ones, bricks_left=15, score retained, state -> PLAY.
REQ-028 start is ignored in PLAY and LOCKOUT.

Reset
REQ-029 rst=0, asynchronously: state=IDLE, alive=15'h7FFF, bricks_left=15, score=0, hit_valid=0, hit_idx=0, level_clear=0, lockout counter=0.
REQ-030 Reset mid-LOCKOUT or mid-pulse aborts immediately; no hit_valid is emitted after rst deasserts.
REQ-031 First state change occurs on the first rising edge after rst deasserts.

Structure
REQ-032 Shared package brick_pkg: NUM_BRICKS=15, IDX_W=4, SCORE_W=8, FSM state enum type.
REQ-033 Sub-module brick_prio_enc: combinational 15-bit lowest-index priority encoder with outputs any and idx.
REQ-034 The lockout counter is sized $clog2(LOCKOUT_FRAMES+1), minimum 1 bit.

Verification
REQ-035 Reset, start, collide=bit3 for 1 cycle -> hit_valid pulse, hit_idx=3, alive=15'h7FF7, score=1, bricks_left=14.
REQ-036 collide=15'h0014 in PLAY -> hit_idx=2 only; alive bit4 stays 1; collide bit4 during next 2 frame_ticks is ignored.
REQ-037 collide held on brick 0 across LOCKOUT (LOCKOUT_FRAMES=2) -> exactly one hit_valid; after the 2nd frame_tick, no further hit.
REQ-038 Destroy all 15 bricks -> bricks_left=0, CLEAR after lockout, level_clear=1; start -> alive=15'h7FFF, score=15 retained.
REQ-039 Preload score=254 with SCORE_STEP=4 -> score=255 after hit, stays 255 on further hits.
REQ-040 rst=0 asserted mid-LOCKOUT -> all outputs at reset values immediately; after release, collide is ignored until start.
